// File: rtl/aes_round_sequencer.sv
// Round-control FSM for an AES datapath: sequences the initial AddRoundKey, NR-1 full
// rounds and the final round, with an ascending key index for encrypt and descending for decrypt.
module aes_round_sequencer #(
    parameter int NR = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_valid,
    output logic       start_ready,
    input  logic       decrypt,
    input  logic       stall,
    input  logic       abort,
    output logic       round_en,
    output logic [3:0] round_idx,
    output logic [3:0] key_idx,
    output logic       first_round,
    output logic       last_round,
    output logic       mode_dec,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    localparam logic [3:0] NR_L  = 4'(NR);
    localparam logic [3:0] NR_M1 = 4'(NR - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    state_t     r_state;
    state_t     w_state_next;

    logic       r_round_en;
    logic [3:0] r_round_idx;
    logic [3:0] r_key_idx;
    logic       r_first_round;
    logic       r_last_round;
    logic       r_mode_dec;
    logic       r_out_valid;

    logic       w_round_en_next;
    logic [3:0] w_round_idx_next;
    logic [3:0] w_key_idx_next;
    logic       w_first_round_next;
    logic       w_last_round_next;
    logic       w_mode_dec_next;
    logic       w_out_valid_next;

    // Decrypt walks the key schedule backwards while the step number still ascends.
    function automatic logic [3:0] key_for(input logic dec, input logic [3:0] ridx);
        return dec ? (NR_L - ridx) : ridx;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_round_en    <= 1'b0;
            r_round_idx   <= 4'd0;
            r_key_idx     <= 4'd0;
            r_first_round <= 1'b0;
            r_last_round  <= 1'b0;
            r_mode_dec    <= 1'b0;
            r_out_valid   <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_round_en    <= w_round_en_next;
            r_round_idx   <= w_round_idx_next;
            r_key_idx     <= w_key_idx_next;
            r_first_round <= w_first_round_next;
            r_last_round  <= w_last_round_next;
            r_mode_dec    <= w_mode_dec_next;
            r_out_valid   <= w_out_valid_next;
        end
    end

    always_comb begin
        // Default is a frozen step: everything holds and no round is issued.
        w_state_next       = r_state;
        w_round_en_next    = 1'b0;
        w_round_idx_next   = r_round_idx;
        w_key_idx_next     = r_key_idx;
        w_first_round_next = r_first_round;
        w_last_round_next  = r_last_round;
        w_mode_dec_next    = r_mode_dec;
        w_out_valid_next   = r_out_valid;

        if (abort) begin
            w_state_next       = S_IDLE;
            w_round_idx_next   = 4'd0;
            w_key_idx_next     = 4'd0;
            w_first_round_next = 1'b0;
            w_last_round_next  = 1'b0;
            w_mode_dec_next    = 1'b0;
            w_out_valid_next   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_valid) begin
                        w_state_next       = S_INIT;
                        w_mode_dec_next    = decrypt;
                        w_round_en_next    = 1'b1;
                        w_first_round_next = 1'b1;
                        w_last_round_next  = 1'b0;
                        w_round_idx_next   = 4'd0;
                        w_key_idx_next     = key_for(decrypt, 4'd0);
                    end
                end
                S_INIT: begin
                    if (!stall) begin
                        w_state_next       = S_ROUND;
                        w_round_en_next    = 1'b1;
                        w_first_round_next = 1'b0;
                        w_round_idx_next   = 4'd1;
                        w_key_idx_next     = key_for(r_mode_dec, 4'd1);
                    end
                end
                S_ROUND: begin
                    if (!stall) begin
                        w_round_en_next  = 1'b1;
                        w_round_idx_next = r_round_idx + 4'd1;
                        w_key_idx_next   = key_for(r_mode_dec, r_round_idx + 4'd1);
                        if (r_round_idx == NR_M1) begin
                            w_state_next      = S_FINAL;
                            w_last_round_next = 1'b1;
                        end
                    end
                end
                S_FINAL: begin
                    // Indices keep their final-round values while the result waits.
                    if (!stall) begin
                        w_state_next      = S_DONE;
                        w_last_round_next = 1'b0;
                        w_out_valid_next  = 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        w_state_next       = S_IDLE;
                        w_round_idx_next   = 4'd0;
                        w_key_idx_next     = 4'd0;
                        w_first_round_next = 1'b0;
                        w_last_round_next  = 1'b0;
                        w_mode_dec_next    = 1'b0;
                        w_out_valid_next   = 1'b0;
                    end
                end
                default: begin
                    w_state_next       = S_IDLE;
                    w_round_idx_next   = 4'd0;
                    w_key_idx_next     = 4'd0;
                    w_first_round_next = 1'b0;
                    w_last_round_next  = 1'b0;
                    w_mode_dec_next    = 1'b0;
                    w_out_valid_next   = 1'b0;
                end
            endcase
        end
    end

    assign start_ready = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign round_en    = r_round_en;
    assign round_idx   = r_round_idx;
    assign key_idx     = r_key_idx;
    assign first_round = r_first_round;
    assign last_round  = r_last_round;
    assign mode_dec    = r_mode_dec;
    assign out_valid   = r_out_valid;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: NR=10 and NR=14 instances driven from a
// vector table, with expected round steps queued at start and popped as round_en appears.
module tb_aes_round_sequencer;

    logic       clk;
    logic       rst_n;
    logic [1:0] start_valid;
    logic [1:0] start_ready;
    logic [1:0] decrypt;
    logic [1:0] stall;
    logic [1:0] abort;
    logic [1:0] round_en;
    logic [3:0] round_idx [2];
    logic [3:0] key_idx [2];
    logic [1:0] first_round;
    logic [1:0] last_round;
    logic [1:0] mode_dec;
    logic [1:0] out_valid;
    logic [1:0] out_ready;
    logic [1:0] busy;

    int n_total;
    int n_pass;

    aes_round_sequencer #(.NR(10)) dut10 (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid[0]), .start_ready(start_ready[0]),
        .decrypt(decrypt[0]), .stall(stall[0]), .abort(abort[0]),
        .round_en(round_en[0]), .round_idx(round_idx[0]), .key_idx(key_idx[0]),
        .first_round(first_round[0]), .last_round(last_round[0]),
        .mode_dec(mode_dec[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .busy(busy[0])
    );

    aes_round_sequencer #(.NR(14)) dut14 (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid[1]), .start_ready(start_ready[1]),
        .decrypt(decrypt[1]), .stall(stall[1]), .abort(abort[1]),
        .round_en(round_en[1]), .round_idx(round_idx[1]), .key_idx(key_idx[1]),
        .first_round(first_round[1]), .last_round(last_round[1]),
        .mode_dec(mode_dec[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ridx;
        int key;
        int first;
        int last;
    } step_t;

    // abort_at: -1 none, 0..14 abort on that round step, 15 abort while in DONE.
    typedef struct {
        int sel;
        int dec;
        int stall_at;
        int stall_len;
        int ready_lag;
        int toggle;
        int abort_at;
        int exp_latency;
        int exp_last_key;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_reset(input int s);
        chk("rst_start_ready", int'(start_ready[s]), 1);
        chk("rst_busy", int'(busy[s]), 0);
        chk("rst_round_en", int'(round_en[s]), 0);
        chk("rst_round_idx", int'(round_idx[s]), 0);
        chk("rst_key_idx", int'(key_idx[s]), 0);
        chk("rst_first_round", int'(first_round[s]), 0);
        chk("rst_last_round", int'(last_round[s]), 0);
        chk("rst_mode_dec", int'(mode_dec[s]), 0);
        chk("rst_out_valid", int'(out_valid[s]), 0);
    endtask

    task automatic run_op(input vec_t v);
        int    s;
        int    nr;
        int    cyc;
        int    stall_left;
        int    guard;
        bit    fin;
        step_t q[$];
        step_t e;

        s          = v.sel;
        nr         = (s == 0) ? 10 : 14;
        cyc        = 0;
        stall_left = 0;
        guard      = 0;
        fin        = 1'b0;

        chk("idle_start_ready", int'(start_ready[s]), 1);
        out_ready[s]   = (v.ready_lag == 0) ? 1'b1 : 1'b0;
        decrypt[s]     = v.dec[0];
        start_valid[s] = 1'b1;
        for (int r = 0; r <= nr; r++) begin
            e.ridx  = r;
            e.key   = (v.dec != 0) ? nr - r : r;
            e.first = (r == 0) ? 1 : 0;
            e.last  = (r == nr) ? 1 : 0;
            q.push_back(e);
        end
        tick();
        start_valid[s] = 1'b0;

        while (!fin) begin
            guard++;
            if (guard > 300) begin
                chk("timeout", 0, 1);
                break;
            end
            if (v.toggle != 0) decrypt[s] = ~decrypt[s];

            if (stall_left > 0) begin
                chk("stall_round_en", int'(round_en[s]), 0);
                chk("stall_round_idx", int'(round_idx[s]), v.stall_at);
                stall_left--;
                if (stall_left == 0) stall[s] = 1'b0;
            end else if (round_en[s]) begin
                if (q.size() == 0) begin
                    chk("extra_round_step", int'(round_idx[s]), -1);
                end else begin
                    e = q.pop_front();
                    chk("step_round_idx", int'(round_idx[s]), e.ridx);
                    chk("step_key_idx", int'(key_idx[s]), e.key);
                    chk("step_first_round", int'(first_round[s]), e.first);
                    chk("step_last_round", int'(last_round[s]), e.last);
                    chk("step_mode_dec", int'(mode_dec[s]), v.dec);
                    chk("step_start_ready", int'(start_ready[s]), 0);
                    if (e.ridx == v.stall_at && v.stall_len > 0) begin
                        stall[s]   = 1'b1;
                        stall_left = v.stall_len;
                    end
                    if (e.ridx == v.abort_at) begin
                        abort[s] = 1'b1;
                        tick();
                        abort[s] = 1'b0;
                        check_reset(s);
                        q.delete();
                        fin = 1'b1;
                    end
                end
            end else if (out_valid[s]) begin
                chk("done_latency", cyc, v.exp_latency);
                chk("done_pending_steps", q.size(), 0);
                chk("done_round_idx", int'(round_idx[s]), nr);
                chk("done_key_idx", int'(key_idx[s]), v.exp_last_key);
                chk("done_busy", int'(busy[s]), 1);
                if (v.abort_at == 15) begin
                    abort[s] = 1'b1;
                    tick();
                    abort[s] = 1'b0;
                    check_reset(s);
                end else begin
                    for (int i = 0; i < v.ready_lag; i++) begin
                        start_valid[s] = 1'b1;
                        tick();
                        chk("hold_out_valid", int'(out_valid[s]), 1);
                        chk("hold_key_idx", int'(key_idx[s]), v.exp_last_key);
                        chk("hold_start_ready", int'(start_ready[s]), 0);
                    end
                    start_valid[s] = 1'b0;
                    out_ready[s]   = 1'b1;
                    tick();
                    chk("xfer_out_valid", int'(out_valid[s]), 0);
                    chk("xfer_start_ready", int'(start_ready[s]), 1);
                    chk("xfer_busy", int'(busy[s]), 0);
                    chk("xfer_round_en", int'(round_en[s]), 0);
                end
                fin = 1'b1;
            end else begin
                chk("gap_cycle_round_en", int'(round_en[s]), 1);
            end

            if (!fin) begin
                tick();
                cyc++;
            end
        end
        stall[s]       = 1'b0;
        abort[s]       = 1'b0;
        start_valid[s] = 1'b0;
        out_ready[s]   = 1'b1;
    endtask

    vec_t vecs[10];

    initial begin
        n_total     = 0;
        n_pass      = 0;
        rst_n       = 1'b0;
        start_valid = '0;
        decrypt     = '0;
        stall       = '0;
        abort       = '0;
        out_ready   = '1;

        //          sel dec stall_at len lag tog abort lat lastkey
        vecs[0] = '{0, 0, -1, 0, 0, 0, -1, 11, 10};
        vecs[1] = '{0, 1, -1, 0, 0, 1, -1, 11, 0};
        vecs[2] = '{0, 0,  5, 3, 0, 0, -1, 14, 10};
        vecs[3] = '{0, 0, -1, 0, 4, 0, -1, 11, 10};
        vecs[4] = '{0, 0, -1, 0, 0, 0,  7, 11, 10};
        vecs[5] = '{0, 1, -1, 0, 0, 0, -1, 11, 0};
        vecs[6] = '{0, 0, -1, 0, 1, 0, 15, 11, 10};
        vecs[7] = '{0, 1, -1, 0, 0, 0, -1, 11, 0};
        vecs[8] = '{1, 0, -1, 0, 0, 0, -1, 15, 14};
        vecs[9] = '{1, 1, 12, 2, 0, 0, -1, 17, 0};

        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_reset(0);
        check_reset(1);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i]);
            tick();
        end

        // Abort in IDLE outranks a start request.
        abort[0]       = 1'b1;
        start_valid[0] = 1'b1;
        tick();
        abort[0]       = 1'b0;
        start_valid[0] = 1'b0;
        check_reset(0);

        // Reset in the middle of an NR=14 operation.
        decrypt[1]     = 1'b1;
        start_valid[1] = 1'b1;
        tick();
        start_valid[1] = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("midrun_busy", int'(busy[1]), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset(1);
        tick();
        check_reset(1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
